// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a program as a byte stream over a valid/ready handshake,
//            packs the bytes big-endian into 32-bit words and writes them to
//            the instruction store from word address 0. Holds the processor
//            PC in clear until the load completes.
// Ports    : clk, clr_n (async active-low reset)
//            start, load_len          - load request and word count
//            byte_valid, byte_data    - byte stream in
//            byte_ready               - byte accepted this cycle
//            imem_we/addr/wdata       - instruction store write port
//            cpu_hold                 - PC clear, high until load completes
//            load_done, load_err      - completion status in DONE
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // Store depth expressed in the length width, so a full-store load is legal.
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     len;
  logic [ADDR_W:0]     word_cnt;
  logic [1:0]          byte_cnt;
  logic [DATA_W-1:0]   word;
  logic [ADDR_W-1:0]   addr;
  logic                err;
  logic [ADDR_W:0]     cnt_inc;

  assign cnt_inc = word_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      word     <= '0;
      addr     <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        // DONE re-arms exactly like IDLE.
        IDLE, DONE: begin
          if (start) begin
            len <= load_len;
            if (load_len == '0) begin
              state <= DONE;
              err   <= 1'b0;
            end else if (load_len > DEPTH) begin
              state <= DONE;
              err   <= 1'b1;
            end else begin
              state    <= RECV;
              err      <= 1'b0;
              word_cnt <= '0;
              byte_cnt <= '0;
            end
          end
        end
        RECV: begin
          if (byte_valid) begin
            word     <= {word[DATA_W-9:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= WRITE;
              // word_cnt is below DEPTH here, so the truncation never wraps.
              addr  <= word_cnt[ADDR_W-1:0];
            end
          end
        end
        WRITE: begin
          word_cnt <= cnt_inc;
          if (cnt_inc == len) begin
            state <= DONE;
          end else begin
            state    <= RECV;
            byte_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  assign byte_ready = (state == RECV);
  assign imem_we    = (state == WRITE);
  assign imem_addr  = addr;
  assign imem_wdata = word;
  assign cpu_hold   = (state != DONE);
  assign load_done  = (state == DONE) && !err;
  assign load_err   = (state == DONE) && err;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed self-checking bench for imem_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Write recorder: logs every store write with the edge index it was seen on.
  int          cyc = 0;
  int          nw  = 0;
  logic [ADDR_W-1:0] wa [0:127];
  logic [31:0] wd [0:127];
  int          wc [0:127];

  always @(posedge clk) begin
    if (imem_we && nw < 128) begin
      wa[nw] = imem_addr;
      wd[nw] = imem_wdata;
      wc[nw] = cyc;
      nw     = nw + 1;
    end
    cyc = cyc + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   guard;
    byte_data  = b;
    byte_valid = 1'b1;
    guard      = 0;
    do begin
      acc = byte_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_hold"},   {63'd0, cpu_hold},   64'd1);
    chk({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    chk({tag, "_imem_we"},    {63'd0, imem_we},    64'd0);
    chk({tag, "_imem_addr"},  {58'd0, imem_addr},  64'd0);
    chk({tag, "_imem_wdata"}, {32'd0, imem_wdata}, 64'd0);
    chk({tag, "_load_done"},  {63'd0, load_done},  64'd0);
    chk({tag, "_load_err"},   {63'd0, load_err},   64'd0);
  endtask

  logic [7:0] prog [0:7];
  int         s;
  int         addr_ok;
  logic [31:0] w;

  initial begin
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h8C; prog[5] = 8'h09; prog[6] = 8'h00; prog[7] = 8'h00;
    clr_n      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // ---- reset then idle ----
    tick(); tick();
    clr_n = 1'b1;
    tick(); tick();
    check_reset_outputs("idle");

    // ---- load_len=2, no gaps ----
    s = cyc;
    do_start(7'd2);
    chk("ready_after_start", {63'd0, byte_ready}, 64'd1);
    nw = 0;
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    byte_valid = 1'b0;
    chk("last_write_active", {63'd0, imem_we}, 64'd1);
    tick();
    chk("nogap_done",      {63'd0, load_done}, 64'd1);
    chk("nogap_hold_low",  {63'd0, cpu_hold},  64'd0);
    chk("nogap_nwrites",   nw,      64'd2);
    chk("nogap_a0",        wa[0],   64'd0);
    chk("nogap_d0",        wd[0],   64'h20080005);
    chk("nogap_a1",        wa[1],   64'd1);
    chk("nogap_d1",        wd[1],   64'h8C090000);
    chk("nogap_t0",        wc[0] - s, 64'd5);
    chk("nogap_t1",        wc[1] - s, 64'd10);
    tick();
    chk("done_holds",      {63'd0, load_done}, 64'd1);
    chk("addr_holds",      {58'd0, imem_addr}, 64'd1);

    // ---- same load with a 3-cycle gap between bytes 2 and 3 ----
    s = cyc;
    do_start(7'd2);
    nw = 0;
    send_byte(prog[0]);
    send_byte(prog[1]);
    byte_valid = 1'b0;
    tick(); tick(); tick();
    for (int i = 2; i < 8; i++) send_byte(prog[i]);
    byte_valid = 1'b0;
    tick();
    chk("gap_done",    {63'd0, load_done}, 64'd1);
    chk("gap_nwrites", nw,      64'd2);
    chk("gap_a0",      wa[0],   64'd0);
    chk("gap_d0",      wd[0],   64'h20080005);
    chk("gap_a1",      wa[1],   64'd1);
    chk("gap_d1",      wd[1],   64'h8C090000);
    chk("gap_t0",      wc[0] - s, 64'd8);
    chk("gap_t1",      wc[1] - s, 64'd13);

    // ---- async reset mid-RECV ----
    do_start(7'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_valid = 1'b0;
    chk("recv_before_rst", {63'd0, byte_ready}, 64'd1);
    #1;
    clr_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    clr_n = 1'b1;
    tick();

    // ---- load_len=0 from IDLE ----
    nw = 0;
    byte_valid = 1'b1;  // ignored outside RECV
    byte_data  = 8'hFF;
    do_start(7'd0);
    chk("len0_done",  {63'd0, load_done}, 64'd1);
    chk("len0_err",   {63'd0, load_err},  64'd0);
    chk("len0_hold",  {63'd0, cpu_hold},  64'd0);
    chk("len0_ready", {63'd0, byte_ready}, 64'd0);

    // ---- load_len=65 from DONE -> error ----
    do_start(7'd65);
    chk("len65_err",  {63'd0, load_err},  64'd1);
    chk("len65_done", {63'd0, load_done}, 64'd0);
    chk("len65_hold", {63'd0, cpu_hold},  64'd0);
    tick(); tick();
    chk("len0_65_nowrites", nw, 64'd0);
    byte_valid = 1'b0;

    // ---- load_len=64, full store ----
    nw = 0;
    do_start(7'd64);
    chk("len64_hold", {63'd0, cpu_hold}, 64'd1);
    chk("len64_err_clr", {63'd0, load_err}, 64'd0);
    for (int i = 0; i < 64; i++) begin
      w = {i[7:0], ~i[7:0], i[7:0] + 8'h40, 8'h5A};
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    byte_valid = 1'b0;
    tick();
    chk("len64_done",    {63'd0, load_done}, 64'd1);
    chk("len64_nwrites", nw,      64'd64);
    addr_ok = 1;
    for (int i = 0; i < 64; i++) if (wa[i] != i[ADDR_W-1:0]) addr_ok = 0;
    chk("len64_addr_seq", addr_ok, 64'd1);
    chk("len64_last_a",   wa[63],  64'd63);
    chk("len64_last_d",   wd[63],  64'h3FC07F5A);
    chk("len64_first_d",  wd[0],   64'h00FF405A);
    chk("len64_addr_hold", {58'd0, imem_addr}, 64'd63);

    // ---- re-arm from DONE with load_len=1 ----
    nw = 0;
    do_start(7'd1);
    chk("rearm_hold",  {63'd0, cpu_hold},  64'd1);
    chk("rearm_done",  {63'd0, load_done}, 64'd0);
    send_byte(8'hAC);
    send_byte(8'h0A);
    send_byte(8'h00);
    send_byte(8'h04);
    byte_valid = 1'b0;
    tick();
    chk("rearm_nwrites", nw,    64'd1);
    chk("rearm_a0",      wa[0], 64'd0);
    chk("rearm_d0",      wd[0], 64'hAC0A0004);
    chk("rearm_done2",   {63'd0, load_done}, 64'd1);
    chk("rearm_hold2",   {63'd0, cpu_hold},  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
